// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encoding and frame constants for the UART boot loader.
package boot_loader_pkg;
    typedef enum logic [2:0] {IDLE, L_ADDR, L_LEN, L_DATA, L_CSUM, R_ADDR, RESP, RUN} bl_state_t;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam int ADDR_BYTES = 4;
    localparam int LEN_BYTES = 2;
endpackage

// File: rtl/bl_word_packer.sv
// bl_word_packer: packs data bytes into 32-bit words and runs the memory write handshake.
module bl_word_packer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic        last,
    input  logic [7:0]  byte_data,
    input  logic [31:0] byte_addr,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        overrun
);
    logic [31:0] acc_data, data_n;
    logic [3:0]  acc_strb, strb_n;
    logic        issue, busy;
    always_comb begin
        data_n  = acc_data | (32'(byte_data) << {byte_addr[1:0], 3'b000});
        strb_n  = acc_strb | (4'b0001 << byte_addr[1:0]);
        issue   = byte_valid && (byte_addr[1:0] == 2'd3 || last);
        // an ack this cycle frees the port, so a new word may issue alongside it
        busy    = mem_req && !mem_ack;
        overrun = issue && busy;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_data  <= '0;
            acc_strb  <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            if (clear || issue) begin
                acc_data <= '0;
                acc_strb <= '0;
            end else if (byte_valid) begin
                acc_data <= data_n;
                acc_strb <= strb_n;
            end
            if (issue && !busy) begin
                mem_req   <= 1'b1;
                mem_addr  <= {byte_addr[31:2], 2'b00};
                mem_wdata <= data_n;
                mem_wstrb <= strb_n;
            end else if (mem_ack) begin
                mem_req <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses load/run frames from the UART, writes memory, releases the CPU.
module uart_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0] MAGIC_LOAD     = 8'hB0,
    parameter logic [7:0] MAGIC_RUN      = 8'hB1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_complete,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_complete,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    output logic        cpu_reset_n,
    output logic [31:0] boot_addr
);
    bl_state_t   state, state_n;
    logic [1:0]  cnt;
    logic [31:0] addr, timer;
    logic [15:0] len, len_n;
    logic [7:0]  sum;
    logic        err, is_run, in_frame, timeout, overrun;
    assign len_n = {rx_data, len[15:8]};
    always_comb begin
        in_frame = state inside {L_ADDR, L_LEN, L_DATA, L_CSUM, R_ADDR};
        timeout  = in_frame && !rx_complete && timer >= 32'(TIMEOUT_CYCLES - 1);
        state_n  = state;
        case (state)
            IDLE:   if (rx_complete) state_n = rx_data == MAGIC_LOAD ? L_ADDR : rx_data == MAGIC_RUN ? R_ADDR : IDLE;
            L_ADDR: if (rx_complete && cnt == 2'(ADDR_BYTES - 1)) state_n = L_LEN;
            L_LEN:  if (rx_complete && cnt == 2'(LEN_BYTES - 1)) state_n = len_n == 16'd0 ? L_CSUM : L_DATA;
            L_DATA: if (rx_complete && len == 16'd1) state_n = L_CSUM;
            L_CSUM: if (rx_complete) state_n = RESP;
            R_ADDR: if (rx_complete && cnt == 2'(ADDR_BYTES - 1)) state_n = RESP;
            RESP:   if ((tx_complete || !tx_valid) && !mem_req) state_n = is_run ? RUN : IDLE;
            default: ;
        endcase
        if (timeout) state_n = IDLE;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            addr        <= '0;
            len         <= '0;
            sum         <= '0;
            err         <= 1'b0;
            is_run      <= 1'b0;
            timer       <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            boot_addr   <= '0;
            cpu_reset_n <= 1'b0;
        end else begin
            cnt   <= state_n != state ? 2'd0 : rx_complete && state inside {L_ADDR, L_LEN, R_ADDR} ? cnt + 2'd1 : cnt;
            timer <= rx_complete || state_n != state || !in_frame ? 32'd0 : timer + 32'd1;
            // addr doubles as the running write pointer once the data phase starts
            if (rx_complete && (state == L_ADDR || state == R_ADDR)) addr <= {rx_data, addr[31:8]};
            else if (rx_complete && state == L_DATA)                 addr <= addr + 32'd1;
            if (rx_complete && state == L_LEN)       len <= len_n;
            else if (rx_complete && state == L_DATA) len <= len - 16'd1;
            sum <= state == IDLE ? 8'd0 : rx_complete && state == L_DATA ? sum + rx_data : sum;
            err <= state == IDLE ? 1'b0 : err | overrun;
            if (state == IDLE && rx_complete) is_run <= rx_data == MAGIC_RUN;
            if (state == L_CSUM && rx_complete) begin
                tx_valid <= 1'b1;
                tx_data  <= rx_data == sum && !err ? ACK : NAK;
            end else if (state == R_ADDR && state_n == RESP) begin
                tx_valid  <= 1'b1;
                tx_data   <= ACK;
                boot_addr <= {rx_data, addr[31:8]};
            end else if (state == RESP && tx_complete) begin
                tx_valid <= 1'b0;
            end
            if (state == RESP && state_n == RUN) cpu_reset_n <= 1'b1;
        end
    end
    bl_word_packer u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (state == IDLE),
        .byte_valid (rx_complete && state == L_DATA),
        .last       (len == 16'd1),
        .byte_data  (rx_data),
        .byte_addr  (addr),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .overrun    (overrun)
    );
endmodule
